seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 74 +++++++
 tb/tb_seq_detect_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable PAT_LEN-bit pattern and optional overlap.
// Define SEQ_DETECT_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detect_param #(
  parameter int PAT_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic [PAT_LEN-1:0]           pat,
  input  logic                         load,
  input  logic                         overlap,
  output logic                         match,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic [CNT_W-1:0]             match_count
);

  localparam int FW = $clog2(PAT_LEN+1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_shift;
  logic [FW-1:0]      fill_shift;
  logic               accept;
  logic               hit;

  // A hit needs a full window, so stale hist bits never take part while filling.
  always_comb begin
    accept     = in_valid & ~load;
    hist_shift = {hist[PAT_LEN-2:0], in};
    fill_shift = (fill == FULL) ? FULL : fill + FW'(1);
    hit        = accept && (fill_shift == FULL) && (hist_shift == pat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (load) begin
      pat_q <= pat;
      fill  <= '0;
      match <= 1'b0;
    end else if (accept) begin
      hist  <= hist_shift;
      match <= hit;
      if (hit) fill <= overlap ? FULL : '0;
      else     fill <= fill_shift;
    end else begin
      match <= 1'b0;
    end
  end

`ifdef SEQ_DETECT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts on the same edge that raises match, so the count tracks the pulse.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: an 8-bit instance and a 4-bit/2-bit-counter instance.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic  m;
    int    f;
    int    c;
    string nm;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q4[$];

  logic       r8, b8, v8, ld8, ov8, m8;
  logic [7:0] pat8;
  logic [3:0] f8;
  logic [7:0] c8;

  logic       r4, b4, v4, ld4, ov4, m4;
  logic [3:0] pat4;
  logic [2:0] f4;
  logic [1:0] c4;

  seq_detect_param #(.PAT_LEN(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(r8), .in(b8), .in_valid(v8), .pat(pat8), .load(ld8),
    .overlap(ov8), .match(m8), .fill(f8), .match_count(c8)
  );

  seq_detect_param #(.PAT_LEN(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(r4), .in(b4), .in_valid(v4), .pat(pat4), .load(ld4),
    .overlap(ov4), .match(m4), .fill(f4), .match_count(c4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic s8(input logic r, ld, v, b, ov, em, input int ef, input int ec, input string nm);
    exp_t e;
    @(negedge clk);
    r8 = r; ld8 = ld; v8 = v; b8 = b; ov8 = ov;
    e.m = em; e.f = ef; e.c = CNT_ON ? ec : 0; e.nm = nm;
    q8.push_back(e);
  endtask

  task automatic s4(input logic r, ld, v, b, ov, em, input int ef, input int ec, input string nm);
    exp_t e;
    @(negedge clk);
    r4 = r; ld4 = ld; v4 = v; b4 = b; ov4 = ov;
    e.m = em; e.f = ef; e.c = CNT_ON ? ec : 0; e.nm = nm;
    q4.push_back(e);
  endtask

  // Monitor: each expectation applies to the edge following its push.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk({e.nm, "_match8"}, 32'(m8), 32'(e.m));
        chk({e.nm, "_fill8"},  32'(f8), 32'(e.f));
        chk({e.nm, "_cnt8"},   32'(c8), 32'(e.c));
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk({e.nm, "_match4"}, 32'(m4), 32'(e.m));
        chk({e.nm, "_fill4"},  32'(f4), 32'(e.f));
        chk({e.nm, "_cnt4"},   32'(c4), 32'(e.c));
      end
    end
  end

  task automatic drv8();
    logic [7:0] p;
    p = 8'h58;
    s8(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    pat8 = 8'h58;
    s8(0, 1, 0, 0, 0, 0, 0, 0, "load58");
    for (int i = 0; i < 8; i++)
      s8(0, 0, 1, p[7-i], 0, i == 7, (i == 7) ? 0 : i + 1, (i == 7) ? 1 : 0, "single");
    s8(0, 0, 0, 0, 0, 0, 0, 1, "idle_after");
    for (int i = 0; i < 8; i++) begin
      s8(0, 0, 1, p[7-i], 0, i == 7, (i == 7) ? 0 : i + 1, (i == 7) ? 2 : 1, "stall_bit");
      if (i < 7) s8(0, 0, 0, 0, 0, 0, i + 1, 1, "stall_hold");
    end
    s8(0, 0, 0, 0, 0, 0, 0, 2, "stall_idle");
    for (int i = 0; i < 3; i++)
      s8(0, 0, 1, p[7-i], 0, 0, i + 1, 2, "pre_collide");
    s8(0, 1, 1, 1, 0, 0, 0, 0, "load_collide");
    for (int i = 0; i < 8; i++)
      s8(0, 0, 1, p[7-i], 0, i == 7, (i == 7) ? 0 : i + 1, (i == 7) ? 1 : 0, "post_collide");
    for (int i = 0; i < 5; i++)
      s8(0, 0, 1, p[7-i], 0, 0, i + 1, 1, "pre_rst");
    s8(1, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
    for (int i = 5; i < 8; i++)
      s8(0, 0, 1, p[7-i], 0, 0, i - 4, 0, "after_rst");
    // pat_q is now 0 and hist is all zero: only a full window may hit.
    for (int i = 4; i < 8; i++)
      s8(0, 0, 1, 0, 1, 0, i, 0, "zero_fill");
    s8(0, 0, 1, 0, 1, 1, 8, 1, "zero_hit");
    s8(0, 0, 1, 0, 1, 1, 8, 2, "zero_ovl");
    s8(0, 0, 1, 1, 1, 0, 8, 2, "zero_miss");
    s8(1, 1, 1, 1, 1, 0, 0, 0, "rst_prio");
  endtask

  task automatic drv4();
    logic [6:0] st;
    st = 7'b1010101;
    s4(1, 0, 0, 0, 0, 0, 0, 0, "reset4");
    pat4 = 4'b1010;
    s4(0, 1, 0, 0, 1, 0, 0, 0, "load4");
    s4(0, 0, 1, st[6], 1, 0, 1, 0, "ovl_b1");
    s4(0, 0, 1, st[5], 1, 0, 2, 0, "ovl_b2");
    s4(0, 0, 1, st[4], 1, 0, 3, 0, "ovl_b3");
    s4(0, 0, 1, st[3], 1, 1, 4, 1, "ovl_b4");
    s4(0, 0, 1, st[2], 1, 0, 4, 1, "ovl_b5");
    s4(0, 0, 1, st[1], 1, 1, 4, 2, "ovl_b6");
    s4(0, 0, 1, st[0], 1, 0, 4, 2, "ovl_b7");
    s4(0, 1, 0, 0, 1, 0, 0, 0, "reload4");
    // overlap only drops on the completing bit
    s4(0, 0, 1, st[6], 1, 0, 1, 0, "nov_b1");
    s4(0, 0, 1, st[5], 1, 0, 2, 0, "nov_b2");
    s4(0, 0, 1, st[4], 1, 0, 3, 0, "nov_b3");
    s4(0, 0, 1, st[3], 0, 1, 0, 1, "nov_b4");
    s4(0, 0, 1, st[2], 1, 0, 1, 1, "nov_b5");
    s4(0, 0, 1, st[1], 1, 0, 2, 1, "nov_b6");
    s4(0, 0, 1, st[0], 1, 0, 3, 1, "nov_b7");
    s4(0, 1, 0, 0, 1, 0, 0, 0, "reload_sat");
    s4(0, 0, 1, 1, 1, 0, 1, 0, "sat_pre1");
    s4(0, 0, 1, 0, 1, 0, 2, 0, "sat_pre0");
    for (int k = 0; k < 5; k++) begin
      s4(0, 0, 1, 1, 1, 0, (k == 0) ? 3 : 4, (k < 3) ? k : 3, "sat_one");
      s4(0, 0, 1, 0, 1, 1, 4, (k + 1 < 3) ? k + 1 : 3, "sat_hit");
    end
    s4(0, 0, 0, 0, 1, 0, 4, 3, "sat_idle");
  endtask

  initial begin
    r8 = 1'b1; ld8 = 1'b0; v8 = 1'b0; b8 = 1'b0; ov8 = 1'b0; pat8 = '0;
    r4 = 1'b1; ld4 = 1'b0; v4 = 1'b0; b4 = 1'b0; ov4 = 1'b0; pat4 = '0;
    fork
      drv8();
      drv4();
    join
    repeat (3) @(posedge clk);
    #2;
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain4", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
